mem_cmd_issuer: RTL and testbench

- Downstream consumer of the address generator.
- Takes each generated address and turns it into Avalon-MM write and/or read burst commands toward the memory under test.
- Asks the address generator for the next address after each completed transaction.
- Counts transactions and signals test completion to the CSR/control logic.

---
 rtl/rtl_settings_pkg.sv | 48 ++++
 rtl/mem_cmd_issuer.sv | 152 +++++++++++++++
 tb/tb_mem_cmd_issuer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rtl_settings_pkg.sv
// Shared settings for the memory command issuer.
// Holds the default bus widths, the operation-mode enum, the issuer FSM
// state encoding and the bit positions of the CSR test-parameter fields,
// plus a helper that folds the raw 2-bit OP field onto the three real modes.
package rtl_settings_pkg;

  localparam int ADDR_W  = 25;
  localparam int DATA_W  = 64;
  localparam int BURST_W = 11;

  typedef enum logic [1:0] {
    WRITE_OP      = 2'd0,
    READ_OP       = 2'd1,
    WRITE_READ_OP = 2'd2
  } op_mode_t;

  // Plain vector plus constants keeps the encoding readable in legacy flows.
  typedef logic [2:0] issuer_state_t;
  localparam issuer_state_t ST_IDLE  = 3'd0;
  localparam issuer_state_t ST_LOAD  = 3'd1;
  localparam issuer_state_t ST_WRITE = 3'd2;
  localparam issuer_state_t ST_READ  = 3'd3;
  localparam issuer_state_t ST_DONE  = 3'd4;

  // CSR field locations: word index, lsb, width.
  localparam int CSR_N_WORD  = 0;
  localparam int CSR_N_LSB   = 0;
  localparam int CSR_N_W     = 16;
  localparam int CSR_L_WORD  = 1;
  localparam int CSR_L_LSB   = 0;
  localparam int CSR_L_W     = 8;
  localparam int CSR_OP_WORD = 1;
  localparam int CSR_OP_LSB  = 9;
  localparam int CSR_OP_W    = 2;
  localparam int CSR_P_WORD  = 1;
  localparam int CSR_P_LSB   = 16;
  localparam int CSR_P_W     = 8;

  // Raw encoding 3 is reserved and behaves like a plain read.
  function automatic op_mode_t decode_op(input logic [CSR_OP_W-1:0] raw);
    case (raw)
      2'd0:    return WRITE_OP;
      2'd2:    return WRITE_READ_OP;
      default: return READ_OP;
    endcase
  endfunction

endpackage

// File: rtl/mem_cmd_issuer.sv
// Memory command issuer.
// Takes each address from the address generator and issues an Avalon-MM
// write burst, a read burst command, or a write burst followed by a read,
// then pulses next_addr_en_o to advance the generator. Counts transactions
// and pulses test_done_o when the programmed count is exhausted.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_test_i        one-cycle start pulse (honoured only when idle)
//   test_param_i        CSR words: N (count), L (burst len), OP, P (seed)
//   next_addr_i         current address from the address generator
//   next_addr_en_o      one-cycle advance pulse, on the accepting edge
//   amm_*               Avalon-MM master command side
//   busy_o              high from start until the cycle after DONE
//   test_done_o         one-cycle pulse while in DONE
//
// Avalon handshake: a command is presented while amm_write_o or amm_read_o
// is high; it is accepted on a clock edge where amm_waitrequest_i is low.
// All command outputs are held unchanged while waitrequest is high.
module mem_cmd_issuer #(
  parameter int ADDR_W  = rtl_settings_pkg::ADDR_W,
  parameter int DATA_W  = rtl_settings_pkg::DATA_W,
  parameter int BURST_W = rtl_settings_pkg::BURST_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_test_i,
  input  logic [2:0][31:0]     test_param_i,
  input  logic [ADDR_W-1:0]    next_addr_i,
  output logic                 next_addr_en_o,
  output logic [ADDR_W-1:0]    amm_address_o,
  output logic                 amm_write_o,
  output logic                 amm_read_o,
  output logic [DATA_W-1:0]    amm_writedata_o,
  output logic [BURST_W-1:0]   amm_burstcount_o,
  input  logic                 amm_waitrequest_i,
  output logic                 busy_o,
  output logic                 test_done_o
);
  import rtl_settings_pkg::*;

  issuer_state_t        state_q, state_d;
  logic [CSR_N_W-1:0]   trans_q, trans_d;
  logic [CSR_L_W-1:0]   len_q, len_d;
  logic [CSR_L_W-1:0]   beat_q, beat_d;
  logic [CSR_P_W-1:0]   pat_q, pat_d;
  op_mode_t             op_q, op_d;
  logic [ADDR_W-1:0]    cmd_addr_q, cmd_addr_d;

  logic [CSR_N_W-1:0]   csr_n;
  logic [CSR_L_W-1:0]   csr_l;
  logic [CSR_OP_W-1:0]  csr_op;
  logic [CSR_P_W-1:0]   csr_p;
  logic                 cmd_active;
  logic                 accept;
  logic                 last_beat;
  logic                 txn_done;
  logic [7:0]           data_byte;
  logic                 unused_params;

  assign csr_n  = test_param_i[CSR_N_WORD][CSR_N_LSB +: CSR_N_W];
  assign csr_l  = test_param_i[CSR_L_WORD][CSR_L_LSB +: CSR_L_W];
  assign csr_op = test_param_i[CSR_OP_WORD][CSR_OP_LSB +: CSR_OP_W];
  assign csr_p  = test_param_i[CSR_P_WORD][CSR_P_LSB +: CSR_P_W];

  // Reserved CSR bits are deliberately ignored.
  assign unused_params = ^{test_param_i[2], test_param_i[0][31:16],
                           test_param_i[1][31:24], test_param_i[1][15:11],
                           test_param_i[1][8]};

  assign amm_write_o = (state_q == ST_WRITE);
  assign amm_read_o  = (state_q == ST_READ);
  assign cmd_active  = amm_write_o | amm_read_o;
  assign accept      = cmd_active & ~amm_waitrequest_i;
  assign last_beat   = (beat_q == len_q - 8'd1);
  assign data_byte   = pat_q + beat_q;  // wraps mod 256

  always_comb begin
    state_d    = state_q;
    trans_d    = trans_q;
    len_d      = len_q;
    beat_d     = beat_q;
    pat_d      = pat_q;
    op_d       = op_q;
    cmd_addr_d = cmd_addr_q;
    txn_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_test_i) begin
          trans_d = csr_n;
          len_d   = (csr_l == '0) ? 8'd1 : csr_l;
          op_d    = decode_op(csr_op);
          pat_d   = csr_p;
          state_d = (csr_n != '0) ? ST_LOAD : ST_DONE;
        end
      end
      ST_LOAD: begin
        // The generator has had one cycle to settle after the last advance.
        cmd_addr_d = next_addr_i;
        beat_d     = '0;
        state_d    = (op_q == READ_OP) ? ST_READ : ST_WRITE;
      end
      ST_WRITE: begin
        if (accept) begin
          beat_d = beat_q + 8'd1;
          if (last_beat) begin
            if (op_q == WRITE_READ_OP) state_d = ST_READ;
            else                       txn_done = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (accept) txn_done = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (txn_done) begin
      trans_d = trans_q - 1'b1;
      state_d = (trans_q == 16'd1) ? ST_DONE : ST_LOAD;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      trans_q    <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      pat_q      <= '0;
      op_q       <= WRITE_OP;
      cmd_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      trans_q    <= trans_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      pat_q      <= pat_d;
      op_q       <= op_d;
      cmd_addr_q <= cmd_addr_d;
    end
  end

  // Command fields are forced to zero whenever no command is presented.
  assign amm_address_o    = cmd_active ? cmd_addr_q : '0;
  assign amm_burstcount_o = cmd_active ? BURST_W'(len_q) : '0;
  assign amm_writedata_o  = amm_write_o ? {(DATA_W/8){data_byte}} : '0;
  assign next_addr_en_o   = txn_done;
  assign busy_o           = (state_q != ST_IDLE);
  assign test_done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_mem_cmd_issuer.sv
// Self-checking bench for mem_cmd_issuer: random and directed tests against
// a transaction-level reference model (expected Avalon command list and
// cycle-count formula).
module tb_mem_cmd_issuer;
  localparam int AW = 25;
  localparam int DW = 64;
  localparam int BW = 11;
  localparam int IW = 3 + AW + BW + DW;  // {next_addr_en, write, read, addr, burst, data}

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2:0][31:0] tparam;
  logic [AW-1:0]   next_addr;
  logic            en;
  logic [AW-1:0]   addr;
  logic            wr;
  logic            rd;
  logic [DW-1:0]   wdata;
  logic [BW-1:0]   bcnt;
  logic            waitreq;
  logic            busy;
  logic            done;

  always #5 clk = ~clk;

  mem_cmd_issuer #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) dut (
    .clk_i(clk), .rst_i(rst), .start_test_i(start), .test_param_i(tparam),
    .next_addr_i(next_addr), .next_addr_en_o(en), .amm_address_o(addr),
    .amm_write_o(wr), .amm_read_o(rd), .amm_writedata_o(wdata),
    .amm_burstcount_o(bcnt), .amm_waitrequest_i(waitreq),
    .busy_o(busy), .test_done_o(done)
  );

  int errors = 0;
  int checks = 0;
  logic [IW-1:0] exp_q[$];
  int en_cnt, done_cnt, busy_cnt, acc_cnt, cyc, stall_mode;
  bit incr_mode, prev_stall, done_now, adv;
  logic [IW-2:0] prev_cmd;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] mk_item(input bit ends, input bit w, input bit r,
      input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [DW-1:0] d);
    return {ends, w, r, a, b, d};
  endfunction

  // Expected accepted commands, in order, for one test.
  task automatic build_model(input int n, input int l, input int op, input logic [7:0] p,
                             input logic [AW-1:0] base, input bit incr);
    int le;
    bit w, r;
    logic [AW-1:0] a;
    logic [7:0] bv;
    le = (l == 0) ? 1 : l;
    w = (op == 0) || (op == 2);
    r = (op != 0);
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      a = base + (incr ? AW'(k) : AW'(0));
      if (w)
        for (int b = 0; b < le; b++) begin
          bv = p + 8'(b);
          exp_q.push_back(mk_item(!r && (b == le - 1), 1'b1, 1'b0, a, BW'(le), {(DW/8){bv}}));
        end
      if (r) exp_q.push_back(mk_item(1'b1, 1'b0, 1'b1, a, BW'(le), '0));
    end
  endtask

  function automatic int exp_latency(input int n, input int l, input int op);
    int le, w, r;
    le = (l == 0) ? 1 : l;
    w = ((op == 0) || (op == 2)) ? 1 : 0;
    r = (op != 0) ? 1 : 0;
    return (n == 0) ? 1 : n * (1 + w * le + r) + 1;
  endfunction

  // Called at the falling edge: observe the current cycle.
  task automatic monitor();
    logic [IW-1:0] obs;
    obs = {en, wr, rd, addr, bcnt, wdata};
    check("wr_rd_excl", {wr, rd} == 2'b11, 1'b0);
    if (prev_stall) check("stall_hold", obs[IW-2:0], prev_cmd);
    if ((wr || rd) && !waitreq) begin
      acc_cnt++;
      if (exp_q.size() == 0) check("extra_cmd", obs, '0);
      else check("cmd", obs, exp_q.pop_front());
      prev_stall = 1'b0;
    end else begin
      check("en_idle", en, 1'b0);
      prev_stall = wr || rd;
      prev_cmd   = obs[IW-2:0];
    end
    en_cnt   += int'(en);
    done_cnt += int'(done);
    busy_cnt += int'(busy);
    done_now = done;
    adv      = en;
  endtask

  // One clock: observe at negedge, then drive the next cycle at posedge+1.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (adv && incr_mode) next_addr = next_addr + 1'b1;
    cyc++;
    case (stall_mode)
      1:       waitreq = ($urandom_range(0, 99) < 40);
      2:       waitreq = (cyc == 3) || (cyc == 4);
      default: waitreq = 1'b0;
    endcase
  endtask

  task automatic setup(input int n, input int l, input int op, input logic [7:0] p,
                       input logic [AW-1:0] base, input bit incr, input int smode);
    build_model(n, l, op, p, base, incr);
    en_cnt = 0; done_cnt = 0; busy_cnt = 0; acc_cnt = 0; cyc = 0;
    next_addr = base; incr_mode = incr; stall_mode = smode;
    waitreq = 1'b0; prev_stall = 1'b0;
    tparam = '0;
    tparam[2] = $urandom;
    tparam[1][8] = 1'($urandom);
    tparam[0][15:0] = 16'(n);
    tparam[1][7:0] = 8'(l);
    tparam[1][10:9] = 2'(op);
    tparam[1][23:16] = p;
  endtask

  task automatic run_test(input int n, input int l, input int op, input logic [7:0] p,
                          input logic [AW-1:0] base, input bit incr, input int smode,
                          input bit extra_start);
    int done_c;
    setup(n, l, op, p, base, incr, smode);
    start = 1'b1;
    done_c = -1;
    for (int c = 0; c < 2000; c++) begin
      step();
      start = extra_start && (c == 2);
      if (extra_start && c == 2) begin
        tparam[0][15:0] = 16'd7;
        tparam[1][7:0] = 8'd5;
        tparam[1][10:9] = 2'd0;
      end
      if (done_now) begin
        done_c = c;
        break;
      end
    end
    start = 1'b0;
    if (done_c < 0) begin
      check("timeout", 1'b0, 1'b1);
      exp_q.delete();
    end else begin
      check("busy_after", busy, 1'b0);
      check("done_after", done, 1'b0);
      check("leftover", exp_q.size(), 0);
      check("en_cnt", en_cnt, n);
      check("done_cnt", done_cnt, 1);
      check("busy_cycles", busy_cnt, done_c);
      if (smode != 1)
        check("latency", done_c, exp_latency(n, l, op) + ((smode == 2) ? 2 : 0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; tparam = '0; next_addr = '0; waitreq = 1'b0;
    incr_mode = 1'b0; stall_mode = 0; prev_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_write", wr, 1'b0);
    check("rst_read", rd, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_en", en, 1'b0);
    check("rst_addr", addr, '0);
    check("rst_bcnt", bcnt, '0);
    check("rst_wdata", wdata, '0);
    rst = 1'b0;

    // Single-beat writes to a fixed address.
    run_test(3, 1, 0, 8'hA5, 25'h100, 1'b0, 0, 1'b0);
    // Four-beat write with pattern wrap and a two-cycle stall on beat 1.
    run_test(1, 4, 0, 8'hFE, 25'h2A5, 1'b0, 2, 1'b0);
    // Write-then-read with an incrementing address.
    run_test(2, 2, 2, 8'($urandom), 25'h10, 1'b1, 0, 1'b0);
    // Empty test for every OP encoding.
    for (int op = 0; op < 4; op++) run_test(0, 3, op, 8'h11, 25'h55, 1'b0, 0, 1'b0);
    // Reserved OP behaves like a read.
    run_test(2, 3, 3, 8'h00, 25'h40, 1'b1, 1, 1'b0);

    // Reset while a write burst is stalled on beat 2.
    setup(1, 4, 0, 8'h3C, 25'h77, 1'b0, 0);
    start = 1'b1;
    for (int c = 0; c < 50; c++) begin
      step();
      start = 1'b0;
      if (acc_cnt == 2) break;
    end
    check("rst_reach_beat2", acc_cnt, 2);
    waitreq = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_write", wr, 1'b0);
    check("midrst_read", rd, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_en", en, 1'b0);
    check("midrst_addr", addr, '0);
    check("midrst_left", exp_q.size(), 2);
    exp_q.delete();
    prev_stall = 1'b0;
    run_test(2, 4, 0, 8'h81, 25'h1F0, 1'b1, 0, 1'b0);

    // Second start while busy is ignored; L=0 issues bursts of one.
    run_test(3, 0, 2, 8'hC3, 25'h300, 1'b1, 0, 1'b1);

    // Randomized tests.
    for (int t = 0; t < 10; t++)
      run_test($urandom_range(1, 5), $urandom_range(0, 6), $urandom_range(0, 3),
               8'($urandom), AW'($urandom), 1'($urandom), $urandom_range(0, 1),
               1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
